// File: rtl/tdm_demux_pkg.sv
// Shared constants and state type for the 4-slot TDM demultiplexer.
package tdm_demux_pkg;

    localparam int N_SLOTS     = 4;
    localparam int SLOT_W      = 2;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4_slot_wr_decoder.sv
// Slot index to one-hot write enable; all enables low unless the beat is accepted.
module slot_wr_decoder
    import tdm_demux_pkg::*;
(
    input  logic [SLOT_W-1:0]  slot,
    input  logic               en,
    output logic [N_SLOTS-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[slot] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM receive demultiplexer: rebuilds framed serial slots into parallel channels.
// Optional frame counter output enabled by defining TDM_DEMUX_FRAME_CNT_EN.
//
// state | meaning
// HUNT  | waiting for a start-of-frame beat; non-SOF beats are dropped
// RUN   | locked to framing; out_slot is the next expected slot index
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [WIDTH-1:0]       in_data,
    output logic [4*WIDTH-1:0]     out_data,
    output logic                   out_valid,
    output logic [SLOT_W-1:0]      out_slot,
    output logic                   sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d, wr_slot;
    logic                accept;
    logic                err_d;
    logic [N_SLOTS-1:0]  we;
    logic                frame_done;
    logic [WIDTH-1:0]    shadow [0:N_SLOTS-2];
    logic [4*WIDTH-1:0]  out_data_q;
    logic                out_valid_q;
    logic                sync_err_q;

    slot_wr_decoder u_slot_wr_decoder (
        .slot (wr_slot),
        .en   (accept),
        .we   (we)
    );

    // The slot-3 enable never lands in a shadow register; it completes the frame.
    assign frame_done = we[N_SLOTS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int k = 0; k < N_SLOTS - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid_q <= frame_done;
            sync_err_q  <= err_d;
            for (int k = 0; k < N_SLOTS - 1; k++) begin
                if (we[k]) begin
                    shadow[k] <= in_data;
                end
            end
            if (frame_done) begin
                out_data_q <= {in_data, shadow[2], shadow[1], shadow[0]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_slot = slot_q;
        accept  = 1'b0;
        err_d   = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        accept  = 1'b1;
                        wr_slot = '0;
                        slot_d  = SLOT_W'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (in_sof) begin
                        // An early SOF restarts the frame at slot 0 and flags the loss.
                        accept  = 1'b1;
                        wr_slot = '0;
                        slot_d  = SLOT_W'(1);
                        err_d   = (slot_q != '0);
                    end else if (slot_q == '0) begin
                        err_d   = 1'b1;
                        slot_d  = '0;
                        state_d = HUNT;
                    end else begin
                        accept  = 1'b1;
                        slot_d  = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_slot  = slot_q;
        sync_err  = sync_err_q;
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
